// File: rtl/row_plane_fetch.sv
// rtl/row_plane_fetch.sv - fetch one scan-pair row for one bit plane from the frame buffer
// Reads upper and lower pixels per column and emits {B2,B1,G2,G1,R2,R1} beats to the shifter.
`timescale 1ns/1ps
module row_plane_fetch #(
  parameter int WIDTH     = 64,
  parameter int HEIGHT    = 64,
  parameter int BIT_DEPTH = 8
) (
  input  logic        in_clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [4:0]  req_row,
  input  logic [2:0]  req_plane,
  output logic        mem_rd_en,
  output logic [11:0] mem_rd_addr,
  input  logic [23:0] mem_rd_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [5:0]  out_col,
  output logic        out_last
);

  localparam int              XW         = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [XW-1:0]   X_LAST     = XW'(WIDTH - 1);
  localparam logic [XW-1:0]   X_ONE      = XW'(1);
  localparam logic [11:0]     HALF_ROWS  = 12'(HEIGHT / 2);
  localparam logic [11:0]     ROW_STRIDE = 12'(WIDTH);
  localparam logic [2:0]      PLANE_MAX  = 3'(BIT_DEPTH - 1);

  typedef enum logic [2:0] {IDLE, RD_UP, RD_LO, CAP, OUT} state_t;

  state_t        state;
  state_t        state_nxt;
  logic [XW-1:0] x;
  logic [XW-1:0] x_inc;
  logic          x_last;
  logic          accept;
  logic [4:0]    row_q;
  logic [2:0]    plane_q;
  logic [11:0]   addr_q;
  logic [23:0]   upper_q;
  logic [7:0]    up_r, up_g, up_b;
  logic [7:0]    lo_r, lo_g, lo_b;

  function automatic logic [11:0] pix_addr(input logic [4:0] r, input logic lower,
                                           input logic [XW-1:0] col);
    logic [11:0] line;
    line = 12'(r) + (lower ? HALF_ROWS : 12'd0);
    return line * ROW_STRIDE + 12'(col);
  endfunction

  assign x_last = (x == X_LAST);
  assign x_inc  = x + X_ONE;
  assign accept = req_valid && req_ready;

  // Lower pixel is taken straight off the read bus in CAP, one cycle after its strobe.
  assign {up_r, up_g, up_b} = upper_q;
  assign {lo_r, lo_g, lo_b} = mem_rd_data;

  assign mem_rd_addr = addr_q;

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RD_UP;
      RD_UP:   state_nxt = RD_LO;
      RD_LO:   state_nxt = CAP;
      CAP:     state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = x_last ? IDLE : RD_UP;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    mem_rd_en = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    case (state)
      IDLE:         req_ready = !rst;
      RD_UP, RD_LO: mem_rd_en = 1'b1;
      OUT: begin
        out_valid = 1'b1;
        out_last  = x_last;
      end
      default: ;
    endcase
  end

  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      x       <= '0;
      row_q   <= '0;
      plane_q <= '0;
      addr_q  <= '0;
      upper_q <= '0;
      out_col <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            row_q   <= req_row;
            plane_q <= (req_plane > PLANE_MAX) ? PLANE_MAX : req_plane;
            x       <= '0;
            addr_q  <= pix_addr(req_row, 1'b0, '0);
          end
        end
        RD_UP: addr_q  <= pix_addr(row_q, 1'b1, x);
        RD_LO: upper_q <= mem_rd_data;
        CAP: out_col <= {lo_b[plane_q], up_b[plane_q], lo_g[plane_q],
                         up_g[plane_q], lo_r[plane_q], up_r[plane_q]};
        OUT: begin
          if (out_ready && !x_last) begin
            x      <= x_inc;
            addr_q <= pix_addr(row_q, 1'b0, x_inc);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_row_plane_fetch.sv
// tb/tb_row_plane_fetch.sv - directed bench for row_plane_fetch
`timescale 1ns/1ps
module tb_row_plane_fetch;

  logic        in_clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [4:0]  req_row = '0;
  logic [2:0]  req_plane = '0;
  logic        mem_rd_en;
  logic [11:0] mem_rd_addr;
  logic [23:0] mem_rd_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [5:0]  out_col;
  logic        out_last;

  logic [23:0] mem [4096];
  logic [11:0] rd_log[$];
  logic [5:0]  beat_col[$];
  logic        beat_last[$];
  int          last_bad = 0;
  int          errors = 0;
  int          checks = 0;

  row_plane_fetch #(.WIDTH(64), .HEIGHT(64), .BIT_DEPTH(8)) dut (
    .in_clk      (in_clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_row     (req_row),
    .req_plane   (req_plane),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_col     (out_col),
    .out_last    (out_last)
  );

  initial forever #31.25 in_clk = ~in_clk;

  // Frame buffer: data one cycle after the strobe, junk otherwise.
  always @(posedge in_clk) mem_rd_data <= mem_rd_en ? mem[mem_rd_addr] : 24'hA5C3E1;

  always @(negedge in_clk) begin
    if (mem_rd_en) rd_log.push_back(mem_rd_addr);
    if (out_valid && out_ready) begin
      beat_col.push_back(out_col);
      beat_last.push_back(out_last);
    end
    if (out_last && !out_valid) last_bad++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic fill(input logic [23:0] v);
    for (int i = 0; i < 4096; i++) mem[i] = v;
  endtask

  task automatic clear_logs();
    rd_log.delete();
    beat_col.delete();
    beat_last.delete();
  endtask

  task automatic send_req(input logic [4:0] r, input logic [2:0] p);
    int n;
    n = 0;
    while (!req_ready && n < 600) begin
      @(posedge in_clk); #1;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL send_req_ready: req_ready=%b required 1", req_ready);
    end
    req_valid = 1'b1;
    req_row   = r;
    req_plane = p;
    @(posedge in_clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc, output int fv, output int lh);
    cyc = 0;
    fv  = -1;
    lh  = -1;
    while (cyc < 3000) begin
      @(negedge in_clk);
      if (out_valid && fv < 0) fv = cyc;
      if (out_valid && out_ready && out_last && lh < 0) lh = cyc;
      if (req_ready) break;
      @(posedge in_clk); #1;
      cyc++;
    end
    @(posedge in_clk); #1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge in_clk);
    @(negedge in_clk);
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL reset_req_ready: got %b required 0", req_ready); end
    checks++; if (mem_rd_en !== 1'b0) begin errors++; $display("FAIL reset_mem_rd_en: got %b required 0", mem_rd_en); end
    checks++; if (mem_rd_addr !== 12'd0) begin errors++; $display("FAIL reset_mem_rd_addr: got %0d required 0", mem_rd_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", out_valid); end
    checks++; if (out_col !== 6'h00) begin errors++; $display("FAIL reset_out_col: got %h required 00", out_col); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b required 0", out_last); end
    @(posedge in_clk); #1;
    rst = 1'b0;
    @(negedge in_clk);
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b required 1", req_ready); end
    @(posedge in_clk); #1;
  endtask

  task automatic test_all_ones();
    int cyc, fv, lh, bad, lbad;
    fill(24'hFFFFFF);
    clear_logs();
    out_ready = 1'b1;
    send_req(5'd0, 3'd0);
    wait_done(cyc, fv, lh);
    checks++; if (fv != 3) begin errors++; $display("FAIL latency: got %0d cycles required 3", fv); end
    checks++; if (cyc != 256) begin errors++; $display("FAIL row_cycles: got %0d required 256", cyc); end
    bad = (beat_col.size() != 64) ? 1 : 0;
    lbad = bad;
    foreach (beat_col[i]) begin
      if (beat_col[i] !== 6'h3F) bad++;
      if (beat_last[i] !== (i == 63)) lbad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ones_beats: %0d beats, %0d wrong, required 64 beats of 3f", beat_col.size(), bad); end
    checks++; if (lbad != 0) begin errors++; $display("FAIL ones_last: %0d bad out_last beats, required last only on beat 64", lbad); end
    bad = (rd_log.size() != 128) ? 1 : 0;
    if (bad == 0) begin
      for (int k = 0; k < 64; k++) begin
        if (rd_log[2*k]   !== 12'(k))        bad++;
        if (rd_log[2*k+1] !== 12'(2048 + k)) bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ones_addrs: %0d reads, %0d bad, required 0,2048,1,2049,...", rd_log.size(), bad); end
  endtask

  task automatic test_single_pixel();
    int cyc, fv, lh, bad;
    fill(24'h000000);
    mem[1989] = 24'h800000;
    mem[4037] = 24'h000080;
    clear_logs();
    send_req(5'd31, 3'd7);
    wait_done(cyc, fv, lh);
    bad = (beat_col.size() != 64) ? 1 : 0;
    foreach (beat_col[i]) if (i != 5 && beat_col[i] !== 6'h00) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL pixel_others: %0d beats, %0d nonzero, required 64 zero beats besides 5", beat_col.size(), bad); end
    // Upper red bit 7 -> R1 (bit 0); lower blue bit 7 -> B2 (bit 5).
    checks++;
    if (beat_col.size() < 6 || beat_col[5] !== 6'b100001) begin
      errors++;
      $display("FAIL pixel_beat5: got %b required 100001", (beat_col.size() > 5) ? beat_col[5] : 6'bx);
    end
    checks++;
    if (rd_log.size() == 0 || rd_log[0] !== 12'd1984) begin
      errors++; $display("FAIL pixel_first_addr: got %0d required 1984", (rd_log.size() > 0) ? rd_log[0] : 12'bx);
    end
    checks++;
    if (rd_log.size() == 0 || rd_log[rd_log.size()-1] !== 12'd4095) begin
      errors++; $display("FAIL pixel_last_addr: got %0d required 4095", (rd_log.size() > 0) ? rd_log[rd_log.size()-1] : 12'bx);
    end
    checks++;
    if (mem_rd_en !== 1'b0 || mem_rd_addr !== 12'd4095) begin
      errors++; $display("FAIL addr_hold: en=%b addr=%0d required en=0 addr=4095", mem_rd_en, mem_rd_addr);
    end
  endtask

  task automatic test_stall();
    int cyc, fv, lh, n, stable_bad, rd_bad, bad;
    logic [5:0] held;
    fill(24'h000000);
    mem[3]    = 24'h010101;
    mem[2051] = 24'h000001;
    clear_logs();
    out_ready = 1'b1;
    send_req(5'd0, 3'd0);
    n = 0;
    while (beat_col.size() < 3 && n < 200) begin
      @(negedge in_clk);
      n++;
    end
    @(posedge in_clk); #1;
    out_ready = 1'b0;
    n = 0;
    do begin
      @(negedge in_clk);
      n++;
    end while (!out_valid && n < 40);
    held = out_col;
    stable_bad = 0;
    rd_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (out_valid !== 1'b1 || out_col !== held) stable_bad++;
      if (mem_rd_en !== 1'b0) rd_bad++;
      @(negedge in_clk);
    end
    @(posedge in_clk); #1;
    out_ready = 1'b1;
    wait_done(cyc, fv, lh);
    checks++; if (held !== 6'h35) begin errors++; $display("FAIL stall_col: got %h required 35", held); end
    checks++; if (stable_bad != 0) begin errors++; $display("FAIL stall_stable: %0d unstable cycles required 0", stable_bad); end
    checks++; if (rd_bad != 0) begin errors++; $display("FAIL stall_no_read: %0d strobes during stall required 0", rd_bad); end
    bad = (beat_col.size() != 64) ? 1 : 0;
    foreach (beat_col[i]) if (beat_col[i] !== ((i == 3) ? 6'h35 : 6'h00)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL stall_beats: %0d beats, %0d wrong, required 64 with beat 3 = 35", beat_col.size(), bad); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL stall_done: req_ready=%b required 1", req_ready); end
  endtask

  task automatic test_req_ignored();
    int cyc, fv, lh, bad;
    fill(24'h000000);
    clear_logs();
    out_ready = 1'b1;
    send_req(5'd1, 3'd0);
    repeat (20) @(posedge in_clk);
    #1;
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL busy_ready: got %b required 0", req_ready); end
    req_valid = 1'b1;
    req_row   = 5'd5;
    req_plane = 3'd3;
    @(posedge in_clk); #1;
    req_valid = 1'b0;
    wait_done(cyc, fv, lh);
    checks++; if (lh < 0 || cyc != lh + 1) begin errors++; $display("FAIL ready_return: ready at %0d, last handshake at %0d, required one cycle later", cyc, lh); end
    bad = (rd_log.size() != 128) ? 1 : 0;
    if (bad == 0) begin
      for (int k = 0; k < 64; k++) begin
        if (rd_log[2*k]   !== 12'(64 + k))   bad++;
        if (rd_log[2*k+1] !== 12'(2112 + k)) bad++;
      end
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL ignored_addrs: %0d reads, %0d bad, required row 1 only", rd_log.size(), bad); end
    repeat (5) @(posedge in_clk);
    #1;
    checks++; if (rd_log.size() != 128 || req_ready !== 1'b1) begin errors++; $display("FAIL not_queued: reads=%0d ready=%b required 128 and 1", rd_log.size(), req_ready); end
    clear_logs();
    send_req(5'd2, 3'd0);
    wait_done(cyc, fv, lh);
    checks++;
    if (rd_log.size() != 128 || rd_log[0] !== 12'd128) begin
      errors++; $display("FAIL new_req: reads=%0d first=%0d required 128 reads from 128", rd_log.size(), (rd_log.size() > 0) ? rd_log[0] : 12'bx);
    end
  endtask

  task automatic test_reset_mid();
    int cyc, fv, lh, n, bad;
    fill(24'hFFFFFF);
    clear_logs();
    out_ready = 1'b1;
    send_req(5'd0, 3'd0);
    n = 0;
    while (beat_col.size() < 20 && n < 300) begin
      @(negedge in_clk);
      n++;
    end
    @(posedge in_clk);
    n = 0;
    do begin
      @(negedge in_clk);
      n++;
    end while (!out_valid && n < 10);
    #5 rst = 1'b1;
    #1;
    checks++;
    if (req_ready !== 1'b0 || mem_rd_en !== 1'b0 || mem_rd_addr !== 12'd0 ||
        out_valid !== 1'b0 || out_col !== 6'h00 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset_outputs: ready=%b en=%b addr=%0d valid=%b col=%h last=%b required all 0",
               req_ready, mem_rd_en, mem_rd_addr, out_valid, out_col, out_last);
    end
    @(posedge in_clk);
    @(posedge in_clk); #1;
    rst = 1'b0;
    clear_logs();
    bad = 0;
    repeat (20) begin
      @(negedge in_clk);
      if (out_valid !== 1'b0 || mem_rd_en !== 1'b0) bad++;
    end
    checks++; if (bad != 0 || req_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_quiet: %0d active cycles ready=%b required 0 and 1", bad, req_ready); end
    @(posedge in_clk); #1;
    clear_logs();
    send_req(5'd0, 3'd0);
    wait_done(cyc, fv, lh);
    bad = (beat_col.size() != 64 || rd_log.size() != 128) ? 1 : 0;
    foreach (beat_col[i]) if (beat_col[i] !== 6'h3F) bad++;
    if (rd_log.size() > 1 && (rd_log[0] !== 12'd0 || rd_log[1] !== 12'd2048)) bad++;
    checks++; if (bad != 0) begin errors++; $display("FAIL restart: beats=%0d reads=%0d errors=%0d required clean row from column 0", beat_col.size(), rd_log.size(), bad); end
  endtask

  task automatic test_plane_sweep();
    int cyc, fv, lh, bad;
    logic [5:0] sweep_exp [8];
    logic [5:0] first;
    // Upper and lower both 362312: R=0011_0110, G=0010_0011, B=0001_0010 by plane.
    sweep_exp = '{6'h0C, 6'h3F, 6'h03, 6'h00, 6'h33, 6'h0F, 6'h00, 6'h00};
    fill(24'h000000);
    for (int c = 0; c < 64; c++) begin
      mem[4*64 + c]  = 24'h362312;
      mem[36*64 + c] = 24'h362312;
    end
    for (int p = 0; p < 8; p++) begin
      clear_logs();
      send_req(5'd4, 3'(p));
      wait_done(cyc, fv, lh);
      bad = (beat_col.size() != 64) ? 1 : 0;
      foreach (beat_col[i]) if (beat_col[i] !== sweep_exp[p]) bad++;
      first = (beat_col.size() > 0) ? beat_col[0] : 6'bx;
      checks++;
      if (bad != 0) begin
        errors++; $display("FAIL sweep_plane%0d: got %h (%0d bad) required %h", p, first, bad, sweep_exp[p]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_single_pixel();
    test_stall();
    test_req_ignored();
    test_reset_mid();
    test_plane_sweep();
    checks++;
    if (last_bad != 0) begin errors++; $display("FAIL last_without_valid: %0d cycles required 0", last_bad); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
